// File: rtl/ama_riscv_line_fill_pkg.sv
// Shared memory/cache geometry and the line fill engine types.
// Line addresses are CORE_BYTE_ADDR_BUS byte-address bits minus the in-line offset.
package ama_riscv_line_fill_pkg;

    localparam int CORE_BYTE_ADDR_BUS   = 16;
    localparam int CACHE_LINE_SIZE      = 512;
    localparam int CACHE_LINE_BYTE_ADDR = $clog2(CACHE_LINE_SIZE / 8);
    localparam int MEM_DATA_BUS         = 128;
    localparam int MEM_TRANSFERS_PER_CL = CACHE_LINE_SIZE / MEM_DATA_BUS;
    localparam int MEM_ADDR_BUS         = CORE_BYTE_ADDR_BUS - $clog2(MEM_DATA_BUS / 8);
    localparam int LF_LINE_ADDR_BUS     = CORE_BYTE_ADDR_BUS - CACHE_LINE_BYTE_ADDR;

    // One cache line, viewed flat (.f) or as memory-bus beats (.q)
    typedef union packed {
        logic [CACHE_LINE_SIZE-1:0]                          f;
        logic [MEM_TRANSFERS_PER_CL-1:0][MEM_DATA_BUS-1:0]   q;
    } cache_line_data_t;

    typedef enum logic [2:0] {
        LF_IDLE,
        LF_WB,
        LF_RD,
        LF_WAIT,
        LF_RESP
    } lf_state_t;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/ama_riscv_line_fill.sv
// Line fill/evict engine: optional dirty-victim writeback as BEATS write beats,
// then BEATS read beats assembled into one cache line returned to the cache.
module ama_riscv_line_fill
    import ama_riscv_line_fill_pkg::*;
#(
    parameter int LINE_ADDR_BUS = LF_LINE_ADDR_BUS,
    parameter int BEATS         = MEM_TRANSFERS_PER_CL
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [LINE_ADDR_BUS-1:0] req_addr,
    input  logic                     req_wb,
    input  logic [LINE_ADDR_BUS-1:0] req_wb_addr,
    input  cache_line_data_t         req_wb_data,
    output logic                     rsp_valid,
    output cache_line_data_t         rsp_data,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_we,
    output logic [MEM_ADDR_BUS-1:0]  mem_req_addr,
    output logic [MEM_DATA_BUS-1:0]  mem_req_wdata,
    input  logic                     mem_rsp_valid,
    input  logic [MEM_DATA_BUS-1:0]  mem_rsp_data
);

    localparam int CNT_W = $clog2(BEATS);

    if (!is_pow2(BEATS) || (BEATS != MEM_TRANSFERS_PER_CL) ||
        (LINE_ADDR_BUS + CNT_W != MEM_ADDR_BUS)) begin : g_bad_cfg
        $error("ama_riscv_line_fill: BEATS/LINE_ADDR_BUS inconsistent with memory geometry");
    end

    lf_state_t                state_q, state_d;
    logic [CNT_W-1:0]         wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]         rq_cnt_q, rq_cnt_d;
    logic [CNT_W-1:0]         rs_cnt_q, rs_cnt_d;
    logic [LINE_ADDR_BUS-1:0] addr_q, addr_d;
    logic [LINE_ADDR_BUS-1:0] wb_addr_q, wb_addr_d;
    cache_line_data_t         victim_q, victim_d;
    cache_line_data_t         fill_q, fill_d;

    logic                     req_ready_q, req_ready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic                     mreq_valid_q, mreq_valid_d;
    logic                     mreq_we_q, mreq_we_d;
    logic [MEM_ADDR_BUS-1:0]  mreq_addr_q, mreq_addr_d;
    logic [MEM_DATA_BUS-1:0]  mreq_wdata_q, mreq_wdata_d;

    logic                     mem_acc;
    logic                     rsp_in;
    logic                     rsp_last;

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rq_cnt_d     = rq_cnt_q;
        rs_cnt_d     = rs_cnt_q;
        addr_d       = addr_q;
        wb_addr_d    = wb_addr_q;
        victim_d     = victim_q;
        fill_d       = fill_q;
        mreq_addr_d  = mreq_addr_q;
        mreq_wdata_d = mreq_wdata_q;

        mem_acc  = mreq_valid_q & mem_req_ready;
        // Read data counts independently of requests, so it may land in the accept cycle
        rsp_in   = mem_rsp_valid & ((state_q == LF_RD) | (state_q == LF_WAIT));
        rsp_last = rsp_in & (&rs_cnt_q);

        if (rsp_in) begin
            fill_d.q[rs_cnt_q] = mem_rsp_data;
            rs_cnt_d           = rs_cnt_q + 1'b1;
        end

        case (state_q)
            LF_IDLE: begin
                if (req_valid & req_ready_q) begin
                    addr_d    = req_addr;
                    wb_addr_d = req_wb_addr;
                    victim_d  = req_wb_data;
                    wr_cnt_d  = '0;
                    rq_cnt_d  = '0;
                    rs_cnt_d  = '0;
                    state_d   = req_wb ? LF_WB : LF_RD;
                end
            end
            LF_WB: begin
                if (mem_acc) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (&wr_cnt_q) state_d = LF_RD;
                end
            end
            LF_RD: begin
                if (mem_acc) begin
                    rq_cnt_d = rq_cnt_q + 1'b1;
                    if (&rq_cnt_q) state_d = rsp_last ? LF_RESP : LF_WAIT;
                end
            end
            LF_WAIT: begin
                if (rsp_last) state_d = LF_RESP;
            end
            LF_RESP: state_d = LF_IDLE;
            default: state_d = LF_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it
        req_ready_d  = (state_d == LF_IDLE);
        rsp_valid_d  = (state_d == LF_RESP);
        mreq_valid_d = (state_d == LF_WB) | (state_d == LF_RD);
        mreq_we_d    = (state_d == LF_WB);
        if (state_d == LF_WB) begin
            mreq_addr_d  = {wb_addr_d, wr_cnt_d};
            mreq_wdata_d = victim_d.q[wr_cnt_d];
        end else if (state_d == LF_RD) begin
            mreq_addr_d  = {addr_d, rq_cnt_d};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LF_IDLE;
            wr_cnt_q     <= '0;
            rq_cnt_q     <= '0;
            rs_cnt_q     <= '0;
            addr_q       <= '0;
            wb_addr_q    <= '0;
            victim_q     <= '0;
            fill_q       <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            mreq_valid_q <= 1'b0;
            mreq_we_q    <= 1'b0;
            mreq_addr_q  <= '0;
            mreq_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rq_cnt_q     <= rq_cnt_d;
            rs_cnt_q     <= rs_cnt_d;
            addr_q       <= addr_d;
            wb_addr_q    <= wb_addr_d;
            victim_q     <= victim_d;
            fill_q       <= fill_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            mreq_valid_q <= mreq_valid_d;
            mreq_we_q    <= mreq_we_d;
            mreq_addr_q  <= mreq_addr_d;
            mreq_wdata_q <= mreq_wdata_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = fill_q;
    assign mem_req_valid = mreq_valid_q;
    assign mem_req_we    = mreq_we_q;
    assign mem_req_addr  = mreq_addr_q;
    assign mem_req_wdata = mreq_wdata_q;

endmodule

// File: tb/tb_ama_riscv_line_fill.sv
// Bench for ama_riscv_line_fill: behavioural memory with random ready/latency
// and a line-level reference built from the memory contents at request time.
module tb_ama_riscv_line_fill;
    import ama_riscv_line_fill_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [9:0]       req_addr = '0;
    logic             req_wb = 1'b0;
    logic [9:0]       req_wb_addr = '0;
    cache_line_data_t req_wb_data = '0;
    logic             rsp_valid;
    cache_line_data_t rsp_data;
    logic             mem_req_valid;
    logic             mem_req_ready = 1'b0;
    logic             mem_req_we;
    logic [11:0]      mem_req_addr;
    logic [127:0]     mem_req_wdata;
    logic             mem_rsp_valid = 1'b0;
    logic [127:0]     mem_rsp_data = '0;

    ama_riscv_line_fill dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wb(req_wb), .req_wb_addr(req_wb_addr), .req_wb_data(req_wb_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic we; logic [11:0] addr; logic [127:0] wdata; } beat_t;
    typedef struct packed { int unsigned due; logic [127:0] data; } pend_t;

    int          nvec = 0;
    int          nerr = 0;
    int unsigned cyc = 0;
    logic [127:0] mem [0:4095];
    beat_t       exp_q[$];
    pend_t       pend_q[$];

    int          rdy_pct = 100;
    int unsigned rsp_dly = 1;
    int          stall_beat = -1;
    int          stall_left = 0;
    bit          stray_en = 1'b0;
    int          rsp_given = 0;
    int unsigned last_rsp_cyc = 0;
    int          rsp_pulses = 0;
    int          fills_done = 0;
    bit          held = 1'b0;
    beat_t       held_b;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory: in-order responses rsp_dly cycles after each accepted read
    always @(negedge clk) begin
        if (rst) begin
            pend_q.delete();
            exp_q.delete();
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            held          = 1'b0;
        end else begin
            if (rsp_valid) rsp_pulses++;
            if (held) begin
                chk("hold_valid", mem_req_valid, 1);
                chk("hold_beat", {mem_req_we, mem_req_addr, mem_req_wdata}, held_b);
            end
            mem_req_ready = ($urandom_range(99) < rdy_pct);
            if (mem_req_valid && !mem_req_we && stall_left > 0 &&
                int'(mem_req_addr[1:0]) == stall_beat) begin
                mem_req_ready = 1'b0;
                stall_left--;
            end
            held   = mem_req_valid && !mem_req_ready;
            held_b = {mem_req_we, mem_req_addr, mem_req_wdata};
            if (mem_req_valid && mem_req_ready) begin
                chk("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("beat_we", mem_req_we, b.we);
                    chk("beat_addr", mem_req_addr, b.addr);
                    if (b.we) chk("beat_wdata", mem_req_wdata, b.wdata);
                end
                if (mem_req_we) mem[mem_req_addr] = mem_req_wdata;
                else pend_q.push_back(pend_t'{due: cyc + rsp_dly, data: mem[mem_req_addr]});
            end
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                pend_t r;
                r = pend_q.pop_front();
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = r.data;
                rsp_given++;
                last_rsp_cyc  = cyc;
            end else if (stray_en && pend_q.size() == 0 && exp_q.size() == 0 && !mem_req_valid) begin
                mem_rsp_valid = 1'b1;
            end
        end
    end

    function automatic cache_line_data_t rand_line();
        cache_line_data_t l;
        for (int i = 0; i < 16; i++) l.f[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Queue the expected beats and issue the request; caller has just reached a negedge
    task automatic issue(input logic [9:0] a, input bit wb, input logic [9:0] wa,
                         input cache_line_data_t wd, output cache_line_data_t exp_line);
        for (int i = 0; i < 4; i++)
            if (wb) exp_q.push_back(beat_t'{we: 1'b1, addr: {wa, 2'(i)}, wdata: wd.q[i]});
        for (int i = 0; i < 4; i++)
            exp_q.push_back(beat_t'{we: 1'b0, addr: {a, 2'(i)}, wdata: '0});
        for (int i = 0; i < 4; i++)
            exp_line.q[i] = (wb && wa == a) ? wd.q[i] : mem[{a, 2'(i)}];
        req_valid   = 1'b1;
        req_addr    = a;
        req_wb      = wb;
        req_wb_addr = wa;
        req_wb_data = wd;
    endtask

    // hold_req < 0 keeps req_valid asserted until the response pulse
    task automatic fill(input logic [9:0] a, input bit wb, input logic [9:0] wa,
                        input cache_line_data_t wd, input int exp_lat, input int hold_req);
        cache_line_data_t exp_line;
        int unsigned acc_cyc;
        int k;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        issue(a, wb, wa, wd, exp_line);
        acc_cyc = cyc;
        @(negedge clk);
        k = 1;
        while (!rsp_valid && (cyc - acc_cyc) < 300) begin
            if (hold_req >= 0 && k > hold_req) req_valid = 1'b0;
            if (k <= 3) chk("busy_not_ready", req_ready, 0);
            @(negedge clk);
            k++;
        end
        chk("rsp_seen", rsp_valid, 1);
        if (rsp_valid) begin
            fills_done++;
            chk("rsp_data", rsp_data, exp_line);
            if (exp_lat > 0) chk("latency", cyc - acc_cyc, exp_lat);
            chk("rsp_after_last_data", cyc - last_rsp_cyc, 1);
            chk("all_beats_issued", exp_q.size(), 0);
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("rsp_one_cycle", rsp_valid, 0);
        chk("ready_after_resp", req_ready, 1);
        chk("rsp_data_stable", rsp_data, exp_line);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cache_line_data_t wd, scratch;
        int g0;
        for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_mem_we", mem_req_we, 0);
        chk("rst_mem_addr", mem_req_addr, 0);
        chk("rst_mem_wdata", mem_req_wdata, 0);
        chk("rst_rsp_data", rsp_data, 0);
        #2 rst = 1'b0;

        // Fill-only, zero-wait memory
        for (int i = 0; i < 4; i++) mem[{10'h003, 2'(i)}] = 128'hA0 + 128'(i);
        fill(10'h003, 1'b0, 10'h000, '0, 6, 0);

        // Evict + fill
        for (int i = 0; i < 4; i++) wd.q[i] = 128'hB0 + 128'(i);
        fill(10'h001, 1'b1, 10'h3FF, wd, 10, 0);
        for (int i = 0; i < 4; i++) chk("wb_landed", mem[{10'h3FF, 2'(i)}], 128'hB0 + 128'(i));

        // Backpressure on read beat 1
        stall_beat = 1;
        stall_left = 3;
        fill(10'h155, 1'b0, 10'h000, '0, 9, 0);
        chk("stall_consumed", stall_left, 0);
        stall_beat = -1;

        // Response skew: all requests out before the first data beat
        rsp_dly = 5;
        fill(10'h2AA, 1'b1, 10'h0F0, rand_line(), 14, 0);
        rsp_dly = 1;

        // Reset after two read beats returned
        @(negedge clk);
        g0 = rsp_given;
        issue(10'h077, 1'b0, 10'h000, '0, scratch);
        rsp_dly = 3;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 100 && (rsp_given - g0) < 2; k++) @(negedge clk);
        chk("two_beats_before_rst", (rsp_given - g0) >= 2, 1);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_mem_valid", mem_req_valid, 0);
        chk("mid_rst_mem_we", mem_req_we, 0);
        chk("mid_rst_mem_addr", mem_req_addr, 0);
        chk("mid_rst_rsp_data", rsp_data, 0);
        #2 rst = 1'b0;
        rsp_dly = 1;
        for (int i = 0; i < 4; i++) mem[{10'h077, 2'(i)}] = {$urandom, $urandom, $urandom, $urandom};
        fill(10'h077, 1'b0, 10'h000, '0, 6, 0);

        // Stray responses and req_valid held while busy
        stray_en = 1'b1;
        fill(10'h0C3, 1'b1, 10'h0C3, rand_line(), 10, -1);
        repeat (3) begin
            @(negedge clk);
            chk("stray_no_pulse", rsp_valid, 0);
            chk("stray_idle_ready", req_ready, 1);
        end
        stray_en = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 20; n++) begin
            rdy_pct = $urandom_range(100, 40);
            rsp_dly = $urandom_range(3);
            fill(10'($urandom), 1'($urandom), 10'($urandom), rand_line(), 0, 0);
        end
        rdy_pct = 100;

        repeat (3) @(negedge clk);
        chk("total_rsp_pulses", rsp_pulses, fills_done);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
